// File: rtl/packet_arbiter_rr_pkg.sv
// Shared AXI-Stream types and arbiter state encoding.
//   axis_mosi_t    : TVALID + payload (TDATA, TID, TLAST), master -> slave
//   axis_miso_t    : TREADY, slave -> master
//   ROUTING_HEADER : TID value that marks the first flit of a packet
package packet_arbiter_rr_pkg;

  localparam int AXIS_DATA_W = 16;
  localparam int AXIS_ID_W   = 2;

  localparam logic [AXIS_ID_W-1:0] ROUTING_HEADER = 2'd1;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] TDATA;
    logic [AXIS_ID_W-1:0]   TID;
    logic                   TLAST;
  } axis_data_t;

  typedef struct packed {
    logic       TVALID;
    axis_data_t data;
  } axis_mosi_t;

  typedef struct packed {
    logic TREADY;
  } axis_miso_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search.
//   req   : request vector, one bit per input
//   ptr   : index of the last served input; search starts at ptr+1
//   idx   : first requesting index found scanning ptr+1, ptr+2, ... mod N
//   found : at least one request is set
module rr_priority_picker #(
  parameter int INPUT_NUMBER       = 5,
  parameter int INPUT_NUMBER_WIDTH = $clog2(INPUT_NUMBER)
) (
  input  logic [INPUT_NUMBER-1:0]       req,
  input  logic [INPUT_NUMBER_WIDTH-1:0] ptr,
  output logic [INPUT_NUMBER_WIDTH-1:0] idx,
  output logic                          found
);

  logic [INPUT_NUMBER_WIDTH-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // k=INPUT_NUMBER wraps back to ptr itself, so a lone requester is re-granted
    for (int k = 1; k <= INPUT_NUMBER; k++) begin
      cand = INPUT_NUMBER_WIDTH'((int'(ptr) + k) % INPUT_NUMBER);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/packet_arbiter_rr.sv
// Packet-granular round-robin arbiter for AXI-Stream inputs onto one channel.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   in_mosi_i    : requester streams; a valid flit with TID=ROUTING_HEADER requests
//   in_miso_o    : requester backpressure; only the owner sees out_miso_i
//   out_mosi_o   : shared output channel (all-zero when idle)
//   out_miso_i   : shared channel backpressure
//   grant_o      : owning input index, meaningful while busy_o
//   busy_o       : a packet owns the channel
//   pkt_cnt_o    : completed packets since reset, saturating
module packet_arbiter_rr
  import packet_arbiter_rr_pkg::*;
#(
  parameter int INPUT_NUMBER       = 5,
  parameter int INPUT_NUMBER_WIDTH = $clog2(INPUT_NUMBER),
  parameter int COUNTER_WIDTH      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  axis_mosi_t                    in_mosi_i [INPUT_NUMBER],
  output axis_miso_t                    in_miso_o [INPUT_NUMBER],
  output axis_mosi_t                    out_mosi_o,
  input  axis_miso_t                    out_miso_i,
  output logic [INPUT_NUMBER_WIDTH-1:0] grant_o,
  output logic                          busy_o,
  output logic [COUNTER_WIDTH-1:0]      pkt_cnt_o
);

  localparam logic [INPUT_NUMBER_WIDTH-1:0] PTR_RST = INPUT_NUMBER_WIDTH'(INPUT_NUMBER - 1);

  arb_state_e                    state_q;
  logic [INPUT_NUMBER_WIDTH-1:0] grant_q;
  logic [INPUT_NUMBER_WIDTH-1:0] ptr_q;
  logic [COUNTER_WIDTH-1:0]      cnt_q;

  logic [INPUT_NUMBER-1:0]       req;
  logic [INPUT_NUMBER_WIDTH-1:0] pick_idx;
  logic                          pick_found;
  axis_mosi_t                    gnt_mosi;
  logic                          last_xfer;

  // Only header flits request; body flits of an unserved packet stay invisible.
  always_comb begin
    req = '0;
    for (int i = 0; i < INPUT_NUMBER; i++)
      req[i] = in_mosi_i[i].TVALID && (in_mosi_i[i].data.TID == ROUTING_HEADER);
  end

  rr_priority_picker #(
    .INPUT_NUMBER       (INPUT_NUMBER),
    .INPUT_NUMBER_WIDTH (INPUT_NUMBER_WIDTH)
  ) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign gnt_mosi  = in_mosi_i[grant_q];
  assign last_xfer = (state_q == ARB_LOCKED) && gnt_mosi.TVALID &&
                     out_miso_i.TREADY && gnt_mosi.data.TLAST;

  // Datapath mux; state_q drops asynchronously on reset so this goes idle at once.
  always_comb begin
    out_mosi_o = '0;
    for (int i = 0; i < INPUT_NUMBER; i++) in_miso_o[i] = '0;
    if (state_q == ARB_LOCKED) begin
      out_mosi_o          = gnt_mosi;
      in_miso_o[grant_q]  = out_miso_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_q <= pick_idx;
            state_q <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          // TVALID gaps mid-packet keep the lock; only the TLAST transfer frees it
          if (last_xfer) begin
            ptr_q   <= grant_q;
            state_q <= ARB_IDLE;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = (state_q == ARB_LOCKED);
  assign pkt_cnt_o = cnt_q;

endmodule

// File: tb/tb_packet_arbiter_rr.sv
module tb_packet_arbiter_rr;
  import packet_arbiter_rr_pkg::*;

  localparam int NI = 5;
  localparam int IW = $clog2(NI);
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_mosi_t       in_mosi [NI];
  axis_miso_t       in_miso [NI];
  axis_mosi_t       out_mosi;
  axis_miso_t       out_miso;
  logic [IW-1:0]    grant;
  logic             busy;
  logic [CW-1:0]    cnt;

  axis_mosi_t       s_in_mosi [NI];
  axis_miso_t       s_in_miso [NI];
  axis_mosi_t       s_out_mosi;
  axis_miso_t       s_out_miso;
  logic [IW-1:0]    s_grant;
  logic             s_busy;
  logic [3:0]       s_cnt;

  packet_arbiter_rr #(.INPUT_NUMBER(NI), .COUNTER_WIDTH(CW)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_mosi_i(in_mosi), .in_miso_o(in_miso),
    .out_mosi_o(out_mosi), .out_miso_i(out_miso), .grant_o(grant),
    .busy_o(busy), .pkt_cnt_o(cnt));

  packet_arbiter_rr #(.INPUT_NUMBER(NI), .COUNTER_WIDTH(4)) u_sat (
    .clk_i(clk), .rst_i(rst), .in_mosi_i(s_in_mosi), .in_miso_o(s_in_miso),
    .out_mosi_o(s_out_mosi), .out_miso_i(s_out_miso), .grant_o(s_grant),
    .busy_o(s_busy), .pkt_cnt_o(s_cnt));

  int total = 0;
  int bad   = 0;
  longint cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- stimulus: per-input flit queues ----------------
  axis_data_t fq [NI][$];
  bit         fire [NI];
  bit         gap_en  = 1'b0;
  bit         rnd_rdy = 1'b0;

  task automatic push_pkt(input int i, input int len, input int base);
    axis_data_t d;
    for (int f = 0; f < len; f++) begin
      d.TDATA = AXIS_DATA_W'(base + f);
      d.TID   = (f == 0) ? ROUTING_HEADER : AXIS_ID_W'(0);
      d.TLAST = (f == len - 1);
      fq[i].push_back(d);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) in_mosi[i] = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) fire[i] = in_mosi[i].TVALID && in_miso[i].TREADY;
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (fire[i] && !rst && fq[i].size() > 0) void'(fq[i].pop_front());
        if (fq[i].size() > 0 && !(gap_en && $urandom_range(3) == 0)) begin
          in_mosi[i].TVALID = 1'b1;
          in_mosi[i].data   = fq[i][0];
        end else begin
          in_mosi[i] = '0;
        end
      end
      if (rnd_rdy) out_miso.TREADY = ($urandom_range(3) != 0);
    end
  end

  // ---------------- behavioural model ----------------
  // Channel owner (-1 = free), last served input, completed packet count.
  int     m_owner = -1;
  int     m_ptr   = NI - 1;
  longint m_cnt   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_ptr   = NI - 1;
      m_cnt   = 0;
    end else begin
      cyc++;
      if (m_owner < 0) begin
        for (int k = 1; k <= NI; k++)
          if (m_owner < 0 && in_mosi[(m_ptr + k) % NI].TVALID &&
              in_mosi[(m_ptr + k) % NI].data.TID == ROUTING_HEADER)
            m_owner = (m_ptr + k) % NI;
      end else if (in_mosi[m_owner].TVALID && out_miso.TREADY &&
                   in_mosi[m_owner].data.TLAST) begin
        m_ptr = m_owner;
        if (m_cnt < (64'd1 << CW) - 1) m_cnt++;
        m_owner = -1;
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("busy", busy, m_owner >= 0);
      chk("pkt_cnt", cnt, m_cnt);
      if (m_owner >= 0) begin
        chk("grant", grant, m_owner);
        chk("out_mosi", out_mosi, in_mosi[m_owner]);
      end else begin
        chk("out_mosi_idle", out_mosi, 0);
      end
      for (int i = 0; i < NI; i++)
        chk($sformatf("in_tready[%0d]", i), in_miso[i].TREADY,
            (m_owner == i) ? out_miso.TREADY : 1'b0);
    end
  end

  // ---------------- transfer monitor for literal checks ----------------
  int          glog [$];
  longint      hcyc [$];
  longint      lcyc [$];
  logic [15:0] dlog [$];

  initial forever begin
    @(negedge clk);
    if (!rst && busy && out_mosi.TVALID && out_miso.TREADY) begin
      dlog.push_back(out_mosi.data.TDATA);
      if (out_mosi.data.TID == ROUTING_HEADER) begin
        glog.push_back(int'(grant));
        hcyc.push_back(cyc);
      end
      if (out_mosi.data.TLAST) lcyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    glog.delete(); hcyc.delete(); lcyc.delete(); dlog.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) fq[i].delete();
    clear_logs();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_cnt", cnt, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_dlog(input int n, input int maxc);
    int c = 0;
    while (dlog.size() < n && c < maxc) begin
      @(posedge clk); #2; c++;
    end
    chk("wait_flits", dlog.size(), n);
  endtask

  task automatic wait_glog(input int n, input int maxc);
    int c = 0;
    while (glog.size() < n && c < maxc) begin
      @(posedge clk); #2; c++;
    end
    chk("wait_grants", glog.size(), n);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int exp_ord [6];
    logic [15:0] exp_d [5];
    axis_data_t nh;

    exp_ord = '{0, 1, 2, 3, 4, 0};
    out_miso.TREADY = 1'b1;
    s_out_miso.TREADY = 1'b1;
    for (int i = 0; i < NI; i++) s_in_mosi[i] = '0;

    // reset state
    do_reset();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cnt", cnt, 0);

    // inputs 1 and 3 together, 3-flit packets
    do_reset();
    push_pkt(1, 3, 'h100);
    push_pkt(3, 3, 'h300);
    wait_dlog(6, 40);
    repeat (2) @(posedge clk);
    #2;
    chk("t1_first_grant", glog[0], 1);
    chk("t1_second_grant", glog[1], 3);
    chk("t1_pkt_cnt", cnt, 2);
    chk("t1_burst_len", lcyc[0] - hcyc[0], 2);
    chk("t1_idle_gap", hcyc[1] - lcyc[0], 2);
    chk("t1_data_first", dlog[0], 'h100);
    chk("t1_data_last", dlog[5], 'h302);

    // all inputs, 1-flit packets
    do_reset();
    for (int i = 0; i < NI; i++)
      for (int r = 0; r < 2; r++) push_pkt(i, 1, 'h10 * i + r);
    wait_glog(6, 60);
    for (int k = 0; k < 6; k++) chk($sformatf("t2_order[%0d]", k), glog[k], exp_ord[k]);
    for (int k = 1; k < 6; k++) chk($sformatf("t2_spacing[%0d]", k), hcyc[k] - hcyc[k-1], 2);

    // backpressure stall on input 2 with input 0 waiting
    do_reset();
    push_pkt(2, 4, 'h200);
    wait_dlog(1, 20);
    out_miso.TREADY = 1'b0;
    push_pkt(0, 1, 'h0AA);
    repeat (4) begin
      @(negedge clk);
      chk("t3_grant_held", grant, 2);
      chk("t3_busy", busy, 1);
      chk("t3_in0_tready", in_miso[0].TREADY, 0);
    end
    chk("t3_no_flit_moved", dlog.size(), 1);
    @(posedge clk);
    #2;
    out_miso.TREADY = 1'b1;
    wait_dlog(5, 30);
    exp_d = '{16'h200, 16'h201, 16'h202, 16'h203, 16'h0AA};
    for (int k = 0; k < 5; k++) chk($sformatf("t3_data[%0d]", k), dlog[k], exp_d[k]);
    chk("t3_grant_order0", glog[0], 2);
    chk("t3_grant_order1", glog[1], 0);

    // non-header valid flit never requests
    do_reset();
    nh.TDATA = 16'h444; nh.TID = AXIS_ID_W'(0); nh.TLAST = 1'b1;
    fq[4].push_back(nh);
    repeat (4) begin
      @(negedge clk);
      chk("t4_busy", busy, 0);
      chk("t4_in4_tready", in_miso[4].TREADY, 0);
    end
    chk("t4_no_grant", glog.size(), 0);

    // reset mid-packet
    do_reset();
    push_pkt(0, 4, 'h0C0);
    push_pkt(3, 1, 'h3F0);
    wait_dlog(2, 20);
    rst = 1'b1;
    #1;
    chk("t5_busy_async", busy, 0);
    chk("t5_cnt_async", cnt, 0);
    chk("t5_out_valid_async", out_mosi.TVALID, 0);
    chk("t5_in0_tready_async", in_miso[0].TREADY, 0);
    fq[0].delete();
    push_pkt(0, 1, 'h0D0);
    clear_logs();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    wait_glog(2, 20);
    repeat (2) @(posedge clk);
    #2;
    chk("t5_first_grant", glog[0], 0);
    chk("t5_second_grant", glog[1], 3);
    chk("t5_data0", dlog[0], 'h0D0);
    chk("t5_cnt", cnt, 2);

    // randomized traffic with valid gaps and random backpressure
    do_reset();
    gap_en  = 1'b1;
    rnd_rdy = 1'b1;
    repeat (3000) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NI; i++)
        if (fq[i].size() == 0 && $urandom_range(4) == 0)
          push_pkt(i, $urandom_range(1, 4), $urandom_range(16'hFFFF));
    end
    gap_en  = 1'b0;
    rnd_rdy = 1'b0;
    out_miso.TREADY = 1'b1;
    begin
      int c = 0;
      while ((busy || fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size() + fq[4].size() > 0)
             && c < 300) begin
        @(posedge clk); #2; c++;
      end
      chk("rand_drained", busy || (c >= 300), 0);
    end
    chk("rand_progress", cnt >= 200, 1);

    // counter saturation on a 4-bit instance
    do_reset();
    chk("sat_rst_cnt", s_cnt, 0);
    s_in_mosi[0].TVALID     = 1'b1;
    s_in_mosi[0].data.TDATA = 16'h5A5;
    s_in_mosi[0].data.TID   = ROUTING_HEADER;
    s_in_mosi[0].data.TLAST = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("sat_cnt_10", s_cnt, 10);
    chk("sat_idle_after_last", s_busy, 0);
    chk("sat_grant", s_grant, 0);
    repeat (20) @(posedge clk);
    #2;
    chk("sat_cnt_15", s_cnt, 15);
    s_in_mosi[0] = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/packet_arbiter_rr.md
PACKET_ARBITER_RR -- requirements
Module: packet_arbiter_rr

Interface
REQ-001 SHALL have parameter INPUT_NUMBER, default 5, number of requesting input ports.
REQ-002 SHALL have parameter INPUT_NUMBER_WIDTH, default $clog2(INPUT_NUMBER), grant index width.
REQ-003 SHALL have parameter COUNTER_WIDTH, default 16, packet counter width.
REQ-004 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_mosi_i  input  axis_mosi_t [INPUT_NUMBER]  requester streams.
REQ-007 SHALL have port in_miso_o  output  axis_miso_t [INPUT_NUMBER]  requester backpressure.
REQ-008 SHALL have port out_mosi_o  output  axis_mosi_t  shared output channel.
REQ-009 SHALL have port out_miso_i  input  axis_miso_t  shared channel backpressure.
REQ-010 SHALL have port grant_o  output  INPUT_NUMBER_WIDTH  index of owning input, valid while busy_o.
REQ-011 SHALL have port busy_o  output  1  high while a packet owns the channel.
REQ-012 SHALL have port pkt_cnt_o  output  COUNTER_WIDTH  completed packets since reset.

Function
REQ-013 SHALL implement two states: IDLE and LOCKED.
REQ-014 SHALL treat input i as requesting when in_mosi_i[i].TVALID=1 and in_mosi_i[i].data.TID=ROUTING_HEADER; non-header valid flits SHALL never request.
REQ-015 In IDLE, SHALL pick the first requesting input scanning ptr+1, ptr+2, ... modulo INPUT_NUMBER (ptr = last served index), register it into grant_o, and enter LOCKED next cycle.
REQ-016 In IDLE, SHALL drive out_mosi_o to all-zero and every in_miso_o TREADY=0 (no flit consumed in the arbitration cycle; 1-cycle grant latency).
REQ-017 In LOCKED, SHALL drive out_mosi_o = in_mosi_i[grant_o] and in_miso_o[grant_o] = out_miso_i, all other in_miso_o all-zero, combinationally.
REQ-018 In LOCKED, SHALL return to IDLE on the cycle after a transfer (TVALID and TREADY both 1) with TLAST=1 on the granted input; a header flit carrying TLAST SHALL end the packet likewise.
REQ-019 On that final transfer, ptr SHALL load grant_o and pkt_cnt_o SHALL increment by 1, saturating at all-ones.
REQ-020 Requests raised while LOCKED SHALL wait; no preemption, and the granted input's TVALID dropping mid-packet SHALL NOT release the lock.
REQ-021 Back-to-back packets SHALL incur exactly one IDLE cycle between last flit of one and first flit of the next.
REQ-022 With a single persistent requester, SHALL re-grant that same input each time.
REQ-023 busy_o SHALL equal (state == LOCKED).

Reset
REQ-024 While rst_i=1, SHALL hold state=IDLE, grant_o=0, ptr=INPUT_NUMBER-1 (input 0 highest first priority), pkt_cnt_o=0, busy_o=0.
REQ-025 Assertion of rst_i mid-packet SHALL abandon the packet immediately; outputs SHALL return to IDLE values within the same cycle (asynchronous), and no partial count SHALL be recorded.

Structure
REQ-026 axis_mosi_t, axis_miso_t and ROUTING_HEADER SHALL come from the shared AXI-Stream type package; no local redefinition.
REQ-027 Round-robin search SHALL be a sub-module rr_priority_picker (request vector + ptr in, one-hot/index + found out, purely combinational); state, ptr and counter stay in packet_arbiter_rr.

Verification
REQ-028 Reset, then inputs 1 and 3 raise headers together, 3-flit packets, TREADY=1 -> input 1 granted cycle 1, flits out cycles 2-4, IDLE cycle 5, input 3 granted, pkt_cnt_o=2 at end.
REQ-029 All 5 inputs request continuously, 1-flit packets -> grant order 0,1,2,3,4,0, one packet every 2 cycles.
REQ-030 Input 2 locked, out TREADY=0 for 4 cycles mid-packet, input 0 requesting -> no flit moves, grant_o stays 2, input 0 TREADY=0, resume completes packet intact.
REQ-031 Input 4 sends non-header valid flit in IDLE -> no grant, busy_o=0, TREADY=0.
REQ-032 Assert rst_i after 2nd of 4 flits -> busy_o=0 same cycle, pkt_cnt_o=0; after release, input 0 wins over pending input 3.
REQ-033 COUNTER_WIDTH=4, 17 one-flit packets -> pkt_cnt_o saturates at 15.
